gpio_frame_rx: RTL

Receive-side counterpart of the board's slow-clock/push-pulse GPIO output. Takes an externally generated slow clock, a frame-start push line and a serial data line from the GPIO header. Synchronizes all three into `clk`, assembles MSB-first words on rising edges of the external clock, and presents each word on a valid/ready interface to downstream logic. Sits between the GPIO pins and the accelerator's command/data intake.

---
 rtl/gpio_frame_rx_pkg.sv | 22 ++
 rtl/gpio_frame_rx_if.sv | 26 ++
 rtl/gpio_sync_edge.sv | 40 ++++
 rtl/gpio_frame_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_frame_rx_pkg.sv
// Shared types and defaults for the GPIO frame receiver: FSM state encoding,
// parameter defaults, the external-clock idle level and a counter-width helper.
package gpio_frame_rx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 10000;

  // The external clock idles high, so its synchronizer resets to this level.
  localparam logic CLK_IDLE_LVL = 1'b1;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gpio_frame_rx_if.sv
// Word output channel of the GPIO frame receiver. master = receiver (source),
// slave = downstream consumer.
interface gpio_frame_rx_if #(
  parameter int DATA_W = gpio_frame_rx_pkg::DEF_DATA_W
);

  // Handshake: rx_data is meaningful while rx_valid is high; the word is
  // consumed on any clk edge where rx_valid && rx_ready. The source holds
  // rx_data stable until consumed; rx_ready may change freely.
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/gpio_sync_edge.sv
// Multi-stage input synchronizer with one edge-detect register and a
// registered rise strobe. o_level is delayed to line up with o_rise.
module gpio_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;

  // i_clr returns the chain to its reset image so re-enabling cannot
  // manufacture an edge that the pin never made.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
    end else if (i_clr) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;

endmodule

// File: rtl/gpio_frame_rx.sv
// GPIO frame receiver: synchronizes slow clock / push / data pins, shifts
// MSB-first words and offers them on a valid/ready channel.
// Optional macro GPIO_FRAME_RX_TIMEOUT_EN adds an in-frame clock timeout.
module gpio_frame_rx
  import gpio_frame_rx_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              ext_clk_in,
  input  logic              ext_push_in,
  input  logic              ext_data_in,
  gpio_frame_rx_if.master   rx,
  output logic              frame_err,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int CNT_W = cnt_width(DATA_W);

  logic w_sync_clr;
  logic w_clk_rise, w_clk_level;
  logic w_push_rise, w_push_level;
  logic w_data, w_data_rise;
  logic w_unused_ok;

  assign w_sync_clr  = ~en;
  assign w_unused_ok = ^{w_clk_level, w_push_level, w_data_rise};

  gpio_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CLK_IDLE_LVL)) u_sync_clk (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (w_sync_clr),
    .i_pin   (ext_clk_in),
    .o_level (w_clk_level),
    .o_rise  (w_clk_rise)
  );

  gpio_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_push (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (w_sync_clr),
    .i_pin   (ext_push_in),
    .o_level (w_push_level),
    .o_rise  (w_push_rise)
  );

  gpio_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (w_sync_clr),
    .i_pin   (ext_data_in),
    .o_level (w_data),
    .o_rise  (w_data_rise)
  );

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_err;

  logic [DATA_W-1:0] w_word;
  logic w_last, w_start, w_abort, w_shift, w_done;
  logic w_timeout, w_handshake, w_load, w_drop;

  assign w_word = {r_shift[DATA_W-2:0], w_data};
  assign w_last = (r_bit_cnt == CNT_W'(DATA_W - 1));

`ifdef GPIO_FRAME_RX_TIMEOUT_EN
  localparam int TMO_W = cnt_width(TIMEOUT);
  logic [TMO_W-1:0] r_tmo;
  logic             w_tmo_hit;

  // Fires on the step that would carry the counter to TIMEOUT-1.
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 2));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo <= '0;
    end else if (!en || r_state != ST_SHIFT || w_start || w_abort || w_shift || w_timeout) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`else
  logic w_tmo_hit;
  assign w_tmo_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state. A push rise always wins over a same-cycle clock rise.
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push_rise) w_state_nxt = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_push_rise)                w_state_nxt = ST_SHIFT;
          else if (w_done || w_timeout)   w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: per-cycle events derived from state and strobes.
  always_comb begin
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_handshake = r_valid & rx.rx_ready;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    if (en) begin
      case (r_state)
        ST_IDLE: begin
          w_start = w_push_rise;
        end
        ST_SHIFT: begin
          w_abort   = w_push_rise;
          w_shift   = ~w_push_rise & w_clk_rise;
          w_done    = w_shift & w_last;
          w_timeout = ~w_push_rise & ~w_clk_rise & w_tmo_hit;
        end
        default: ;
      endcase
    end
    w_load = w_done & (~r_valid | rx.rx_ready);
    w_drop = w_done & ~w_load;
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (!en || w_start || w_abort || w_timeout || w_done) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_shift   <= w_word;
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  // Output word holding register; keeps working while en is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
    end else if (w_handshake) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_drop | w_abort | w_timeout;
    end
  end

  assign rx.rx_data  = r_data;
  assign rx.rx_valid = r_valid;
  assign frame_err   = r_err;
  assign busy        = (r_state == ST_SHIFT);
  assign dbg_state   = r_state;

endmodule
